// File: rtl/tt_um_example_pkg.sv
// Shared types and constants for the E-stop safety relay.
// State encoding, default timing and output bit positions.
package tt_um_example_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP   = 2'd0,
    ST_LATCHED   = 2'd1,
    ST_RUN       = 2'd2,
    ST_WDG_FAULT = 2'd3
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES    = 64;
  localparam int DEF_STARTUP_CYCLES     = 50;
  localparam int DEF_WDG_TIMEOUT_CYCLES = 50_000;

  localparam int UI_ESTOP_A = 0;
  localparam int UI_ESTOP_B = 1;
  localparam int UI_ACK_N   = 2;
  localparam int UI_KICK    = 3;

  localparam int UO_SHUTDOWN = 0;
  localparam int UO_LED      = 1;

endpackage

// File: rtl/estop_debounce.sv
// One E-stop channel: 2-flop synchroniser plus stable-count filter.
// Output follows the input only after CYCLES consecutive differing samples.
module estop_debounce #(
  parameter int CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic deb_n
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchronise, then count consecutive samples that disagree with deb.
  always_comb begin
    s1_d  = raw_n;
    s2_d  = s1_q;
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CYCLES - 1)) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Reset is active-high; everything returns to the released level.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      deb_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb_n = deb_q;

endmodule

// File: rtl/tt_um_example.sv
// Dual-channel E-stop safety relay with ack latch and watchdog.
// Load is energised (shutdown_out = 0) only in RUN.
import tt_um_example_pkg::*;

module tt_um_example #(
  parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
  parameter int STARTUP_CYCLES     = DEF_STARTUP_CYCLES,
  parameter int WDG_TIMEOUT_CYCLES = DEF_WDG_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);

  localparam int SCW = $clog2(STARTUP_CYCLES + 1);
  localparam int WCW = $clog2(WDG_TIMEOUT_CYCLES + 1);

  logic deb_a, deb_b;

  logic ack_s1_q, ack_s1_d;
  logic ack_s2_q, ack_s2_d;
  logic ack_pv_q, ack_pv_d;
  logic kck_s1_q, kck_s1_d;
  logic kck_s2_q, kck_s2_d;
  logic kck_pv_q, kck_pv_d;

  state_e         state_q, state_d;
  logic [SCW-1:0] st_cnt_q, st_cnt_d;
  logic [WCW-1:0] wdg_cnt_q, wdg_cnt_d;
  logic           armed_q, armed_d;
  logic           kseen_q, kseen_d;
  logic           shut_q, shut_d;
  logic           led_q, led_d;

  logic pressed, ack_evt, kick_evt, wdg_exp;
  logic unused_ok;

  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:4]};

  estop_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (ui_in[UI_ESTOP_A]),
    .deb_n (deb_a)
  );

  estop_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (ui_in[UI_ESTOP_B]),
    .deb_n (deb_b)
  );

  // Synchronise ack and kick, keep one older sample for edge detect.
  always_comb begin
    ack_s1_d = ui_in[UI_ACK_N];
    ack_s2_d = ack_s1_q;
    ack_pv_d = ack_s2_q;
    kck_s1_d = ui_in[UI_KICK];
    kck_s2_d = kck_s1_q;
    kck_pv_d = kck_s2_q;
  end

  assign pressed  = ~deb_a | ~deb_b;
  assign ack_evt  = ack_pv_q & ~ack_s2_q;
  assign kick_evt = kck_s2_q & ~kck_pv_q;
  assign wdg_exp  = armed_q &&
                    (wdg_cnt_q == WCW'(WDG_TIMEOUT_CYCLES));

  // Main state machine; E-stop always has priority over watchdog.
  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    unique case (state_q)
      ST_STARTUP: begin
        if (st_cnt_q == SCW'(STARTUP_CYCLES - 1)) begin
          state_d = ST_LATCHED;
        end else begin
          st_cnt_d = st_cnt_q + SCW'(1);
        end
      end
      ST_LATCHED: begin
        if (ack_evt && !pressed) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (pressed)      state_d = ST_LATCHED;
        else if (wdg_exp) state_d = ST_WDG_FAULT;
      end
      ST_WDG_FAULT: begin
        if (pressed) begin
          state_d = ST_LATCHED;
        end else if (ack_evt && (kseen_q || kick_evt)) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_STARTUP;
    endcase
  end

  // Watchdog arms on first kick in RUN; saturating gap counter.
  always_comb begin
    armed_d   = armed_q;
    wdg_cnt_d = wdg_cnt_q;
    if (state_q != ST_RUN) begin
      armed_d   = 1'b0;
      wdg_cnt_d = '0;
    end else if (kick_evt) begin
      armed_d   = 1'b1;
      wdg_cnt_d = '0;
    end else if (armed_q && !wdg_exp) begin
      wdg_cnt_d = wdg_cnt_q + WCW'(1);
    end
  end

  // Remember a kick seen while in WDG_FAULT; cleared elsewhere.
  always_comb begin
    kseen_d = 1'b0;
    if (state_q == ST_WDG_FAULT) kseen_d = kseen_q | kick_evt;
  end

  // Registered output decode, one cycle behind the state.
  always_comb begin
    shut_d = (state_q != ST_RUN);
    led_d  = (state_q == ST_RUN);
  end

  // Active-high synchronous reset forces the safe state.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ack_s1_q  <= 1'b1;
      ack_s2_q  <= 1'b1;
      ack_pv_q  <= 1'b1;
      kck_s1_q  <= 1'b0;
      kck_s2_q  <= 1'b0;
      kck_pv_q  <= 1'b0;
      state_q   <= ST_STARTUP;
      st_cnt_q  <= '0;
      wdg_cnt_q <= '0;
      armed_q   <= 1'b0;
      kseen_q   <= 1'b0;
      shut_q    <= 1'b1;
      led_q     <= 1'b0;
    end else begin
      ack_s1_q  <= ack_s1_d;
      ack_s2_q  <= ack_s2_d;
      ack_pv_q  <= ack_pv_d;
      kck_s1_q  <= kck_s1_d;
      kck_s2_q  <= kck_s2_d;
      kck_pv_q  <= kck_pv_d;
      state_q   <= state_d;
      st_cnt_q  <= st_cnt_d;
      wdg_cnt_q <= wdg_cnt_d;
      armed_q   <= armed_d;
      kseen_q   <= kseen_d;
      shut_q    <= shut_d;
      led_q     <= led_d;
    end
  end

  // Drive the pad buses; everything unused is held low.
  always_comb begin
    uo_out              = '0;
    uo_out[UO_SHUTDOWN] = shut_q;
    uo_out[UO_LED]      = led_q;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_example.sv
// Bench for the E-stop relay: directed scenarios plus random
// traffic, checked every cycle against a behavioural model.
module tb_tt_um_example;

  localparam int N = 64;
  localparam int S = 50;
  localparam int T = 50_000;

  localparam int M_START = 0;
  localparam int M_LATCH = 1;
  localparam int M_RUN   = 2;
  localparam int M_FAULT = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int n_vec;
  int n_err;
  bit chk_en;

  tt_um_example dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  logic [7:0] p1, p2, p3;
  bit   deb_a, deb_b;
  bit   qa[$];
  bit   qb[$];
  int   st;
  int   e;
  int   last_kick;
  bit   armed;
  bit   kseen;
  bit   exp_sd;
  bit   exp_led;

  function automatic bit all_differ(input bit q[$], input bit v);
    bit r;
    r = (q.size() == N);
    foreach (q[i]) if (q[i] == v) r = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      p1 = 8'h07; p2 = 8'h07; p3 = 8'h07;
      deb_a = 1'b1; deb_b = 1'b1;
      qa.delete(); qb.delete();
      st = M_START; e = 0; last_kick = 0;
      armed = 1'b0; kseen = 1'b0;
      exp_sd = 1'b1; exp_led = 1'b0;
    end else begin
      automatic bit ack_e  = p3[2] && !p2[2];
      automatic bit kick_e = p2[3] && !p3[3];
      automatic bit press  = !deb_a || !deb_b;
      automatic bit expd;
      automatic int nst;
      e++;
      exp_sd  = (st != M_RUN);
      exp_led = (st == M_RUN);
      expd = armed && (e - last_kick > T);
      nst = st;
      case (st)
        M_START: if (e >= S) nst = M_LATCH;
        M_LATCH: if (ack_e && !press) nst = M_RUN;
        M_RUN: begin
          if (press) nst = M_LATCH;
          else if (expd) nst = M_FAULT;
        end
        default: begin
          if (press) nst = M_LATCH;
          else if (ack_e && (kseen || kick_e)) nst = M_RUN;
        end
      endcase
      if (st == M_RUN) begin
        if (kick_e) begin
          armed = 1'b1;
          last_kick = e;
        end
      end else begin
        armed = 1'b0;
      end
      kseen = (st == M_FAULT) ? (kseen | kick_e) : 1'b0;
      st = nst;
      qa.push_back(p2[0]);
      if (qa.size() > N) void'(qa.pop_front());
      qb.push_back(p2[1]);
      if (qb.size() > N) void'(qb.pop_front());
      if (all_differ(qa, deb_a)) deb_a = !deb_a;
      if (all_differ(qb, deb_b)) deb_b = !deb_b;
      p3 = p2;
      p2 = p1;
      p1 = ui_in;
    end
  end

  // Compare outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      automatic logic [7:0] want = {6'b0, exp_led, exp_sd};
      n_vec++;
      if (uo_out !== want || uio_out !== 8'h00 ||
          uio_oe !== 8'h00) begin
        n_err++;
        $display("FAIL cycle t=%0t uo_out=%b uio_out=%h uio_oe=%h want uo_out=%b",
                 $time, uo_out, uio_out, uio_oe, want);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [1:0] want);
    n_vec++;
    if (uo_out[1:0] !== want) begin
      n_err++;
      $display("FAIL %s led/shutdown=%b want %b", name, uo_out[1:0], want);
    end
  endtask

  task automatic ack_pulse();
    ui_in[2] = 1'b0;
    step(5);
    ui_in[2] = 1'b1;
  endtask

  task automatic kick_pulse();
    ui_in[3] = 1'b1;
    step(5);
    ui_in[3] = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    rst_n = 1'b1; ena = 1'b1; uio_in = 8'h00;
    ui_in = 8'h07;
    step(2);
    chk_en = 1'b1;
    lit("reset_state", 2'b01);
    rst_n = 1'b0;

    step(60);
    lit("after_startup", 2'b01);
    ack_pulse();
    step(100);
    lit("s1_run", 2'b10);

    ui_in[0] = 1'b0;
    step(N + 4);
    lit("s2_latency_a", 2'b01);
    step(100 - N - 4);
    lit("s2_a_held", 2'b01);
    ui_in[0] = 1'b1;
    step(100);
    lit("s2_a_released", 2'b01);
    ack_pulse();
    step(10);
    lit("s2_ack", 2'b10);

    ui_in[1] = 1'b0;
    step(100);
    lit("s3_b_held", 2'b01);
    ui_in[1] = 1'b1;
    step(100);
    lit("s3_b_released", 2'b01);
    ack_pulse();
    step(10);
    lit("s3_ack", 2'b10);
    ui_in[1] = 1'b0;
    step(100);
    ack_pulse();
    step(10);
    lit("s3_ack_while_held", 2'b01);
    ui_in[1] = 1'b1;
    step(100);
    ack_pulse();
    step(10);
    lit("s3_ack_after_release", 2'b10);

    ui_in[0] = 1'b0;
    step(20);
    ui_in[0] = 1'b1;
    step(100);
    lit("s4_glitch", 2'b10);

    for (int i = 0; i < 20; i++) begin
      kick_pulse();
      step(95);
    end
    lit("s5_kicked", 2'b10);
    step(T + 10);
    lit("s5_expired", 2'b01);
    kick_pulse();
    step(10);
    ack_pulse();
    step(10);
    lit("s5_recovered", 2'b10);

    rst_n = 1'b1;
    step(1);
    lit("s6_reset_edge", 2'b01);
    rst_n = 1'b0;
    step(60);
    lit("s6_no_ack", 2'b01);
    ack_pulse();
    step(20);
    lit("s6_rerun", 2'b10);

    for (int seg = 0; seg < 60; seg++) begin
      automatic int len = $urandom_range(1, 120);
      automatic logic [7:0] v = 8'($urandom);
      v[0] = ($urandom_range(0, 7) != 0);
      v[1] = ($urandom_range(0, 7) != 0);
      v[2] = ($urandom_range(0, 3) != 0);
      uio_in = 8'($urandom);
      ena = 1'($urandom);
      ui_in = v;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b1;
        step(1);
        rst_n = 1'b0;
      end
      step(len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_example.md
TT_UM_EXAMPLE -- requirements
Module: tt_um_example

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset; asserted when 1 despite the name.
- ui_in  in  8  [0] estop_a_n, [1] estop_b_n, [2] ack_n (all active-low); [3] wdg_kick (active-high); [7:4] unused.
- uo_out  out  8  [0] shutdown_out (1 = load de-energised); [1] led_status; [7:2] tied 0.
- uio_in  in  8  unused.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0.
- ena  in  1  ignored.
REQ-003 Parameters SHALL be:
- DEBOUNCE_CYCLES, default 64: stable-sample count for the E-stop channels; must stay below 100.
- STARTUP_CYCLES, default 50: post-reset hold time.
- WDG_TIMEOUT_CYCLES, default 50_000: maximum kick-to-kick gap.

Function
REQ-004 All four ui_in inputs SHALL pass through a 2-flop synchroniser before any use.
REQ-005 Each E-stop channel SHALL be debounced independently.
- The debounced value changes only after the synchronised input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
- Each debounced value resets to 1 (released).
REQ-006 The active-low pressed condition is estop_pressed = !deb_a OR !deb_b; either channel alone SHALL trigger shutdown.
REQ-007 The ack event SHALL be a single-cycle pulse on a falling edge of synchronised ack_n, with no debounce, so a 5-cycle low pulse registers.
REQ-008 The kick event SHALL be a single-cycle pulse on a rising edge of synchronised wdg_kick.
REQ-009 The FSM SHALL have four states: STARTUP, LATCHED, RUN and WDG_FAULT.
REQ-010 STARTUP SHALL go to LATCHED after STARTUP_CYCLES cycles, regardless of input levels.
REQ-011 LATCHED SHALL go to RUN on an ack event only when estop_pressed = 0 in that cycle; otherwise the ack is ignored and not remembered.
REQ-012 RUN transitions:
- To LATCHED when estop_pressed = 1.
- Otherwise to WDG_FAULT on watchdog expiry.
- If both occur in the same cycle, the E-stop wins.
REQ-013 WDG_FAULT transitions:
- To LATCHED when estop_pressed = 1.
- Otherwise to RUN on an ack event, provided a kick event has been seen since entering WDG_FAULT.
REQ-014 Watchdog arming and counting:
- The watchdog is armed by the first kick event in RUN and disarmed in every other state.
- While armed, a counter increments each cycle and clears on each kick event.
- Expiry occurs when the count reaches WDG_TIMEOUT_CYCLES.
- The counter saturates and never wraps.
REQ-015 Output decode shall be registered:
- shutdown_out = 0 only in RUN; 1 in all other states.
- led_status = 1 only in RUN; 0 in all other states.
- Outputs change one cycle after the state change.
REQ-016 Response latency from the ui_in E-stop edge to shutdown_out = 1 SHALL be at most DEBOUNCE_CYCLES + 4 cycles.

Reset
REQ-017 While rst_n = 1 at a clock edge, the block SHALL reset all state:
- State is STARTUP; all counters are 0.
- Synchronisers and debouncers are set to the released/idle level.
- shutdown_out = 1, led_status = 0, all other outputs 0.
REQ-018 Asserting reset in any state, including mid-RUN, SHALL force shutdown_out = 1 on the next edge.

Structure
REQ-019 A shared package SHALL hold:
- The state enum (STARTUP, LATCHED, RUN, WDG_FAULT).
- The default parameter constants.
- The uo_out bit-index constants.
REQ-020 Sub-module: one sub-module, estop_debounce, SHALL be instantiated once per E-stop channel and contain the synchroniser plus the stable-count filter.

Verification
REQ-021 The bench SHALL cover the following six scenarios:
- Reset, then 60 cycles, then ack pulse, wait 100 cycles -> shutdown=0, LED=1.
- In RUN, estop_a_n=0 for 100 cycles -> shutdown=1, LED=0. Release, wait 100 cycles -> still 1/0. Ack pulse -> 0/1.
- Same sequence on estop_b_n alone -> identical result. An ack while B is still held -> stays 1/0.
- estop_a_n low for 20 cycles then high (glitch) in RUN -> shutdown stays 0.
- In RUN, kick every 100 cycles for 2000 cycles -> stays 0/1. Stop kicking, wait WDG_TIMEOUT_CYCLES+10 cycles -> 1/0. Kick, then ack -> 0/1.
- Assert rst_n=1 mid-RUN for one cycle -> shutdown=1 on the next edge. After 60 cycles without ack -> still 1/0.
